uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, TX buffer entries; power of two, at least 2.
REQ-002 Parameter DIV_W, default 16, width of the baud divisor.
REQ-003 clk  input  1  system clock; all logic on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_data  input  8  byte to transmit; bits above the configured data length are ignored.
REQ-006 in_valid  input  1  byte offered; accepted on a cycle where in_valid && in_ready.
REQ-007 in_ready  output  1  FIFO not full.
REQ-008 cfg_div  input  DIV_W  bit period equals cfg_div+1 clk cycles.
REQ-009 cfg_dbits  input  2  data length: 0=5, 1=6, 2=7, 3=8 bits.
REQ-010 cfg_parity  input  2  0=none, 1=even, 2=odd, 3=none.
REQ-011 cfg_stop2  input  1  0=one stop bit, 1=two stop bits.
REQ-012 tx  output  1  serial line, idle high, driven from a flop.
REQ-013 tx_busy  output  1  high while a frame is in progress (state != IDLE).
REQ-014 tx_done  output  1  one-cycle pulse on the last cycle of the final stop bit.
REQ-015 fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-016 The FIFO SHALL be a first-in first-out buffer; a push and a pop in the same cycle SHALL leave the level unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-017 in_ready SHALL be low exactly when fifo_level == FIFO_DEPTH; no push SHALL occur while full.
REQ-018 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-019 In IDLE with the FIFO non-empty, the FSM SHALL pop one byte, latch it, latch all cfg_* inputs, clear the baud counter and enter START.
REQ-020 A byte pushed into an empty idle block SHALL drive tx low on the second rising edge after the accepting edge.
REQ-021 Each bit SHALL last exactly cfg_div+1 cycles; the baud counter SHALL run only outside IDLE.
REQ-022 cfg_div = 0 SHALL give one-cycle bits.
REQ-023 Bit order SHALL be: START (tx=0); then DATA, LSB first, for the latched length; then PARITY when enabled; then STOP (tx=1) for 1 or 2 bit periods.
REQ-024 Even parity SHALL make the total count of ones in data+parity even; odd parity SHALL make it odd; only the transmitted data bits SHALL count.
REQ-025 After STOP, the FSM SHALL return to IDLE.
REQ-026 When the FIFO is non-empty at that point, the next START SHALL begin on the following cycle, giving back-to-back frames with one extra idle-high cycle.
REQ-027 cfg_* changes during a frame SHALL NOT affect that frame; they SHALL take effect at the next frame start.
REQ-028 Pushes during a frame SHALL be accepted normally.
REQ-029 Popping SHALL occur only in IDLE.
REQ-030 tx SHALL remain high in IDLE.

Reset
REQ-031 While rst is high, and immediately when it asserts mid-frame, the block SHALL force: tx=1, tx_busy=0, tx_done=0, FSM=IDLE, FIFO empty (fifo_level=0, in_ready=1), counters 0.
REQ-032 The byte in flight and all FIFO contents SHALL be discarded.
REQ-033 The FIFO storage array SHALL need no reset.

Structure
REQ-034 Package uart_pkg SHALL hold the FSM state encoding, the parity mode constants and the data-length decode constants.
REQ-035 The FIFO SHALL be a separate sub-module sync_fifo, parameterised by width and depth, with push/pop/full/empty/level ports; uart_tx_fifo SHALL instantiate it with width 8.

Verification
REQ-036 8N1, cfg_div=3, push 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; frame 40 cycles; one tx_done pulse.
REQ-037 7 data bits, even parity, cfg_div=1, push 0x55 -> data 1,0,1,0,1,0,1 then parity 0 then stop 1; a second run with odd parity -> parity 1.
REQ-038 5 data bits, two stop bits, cfg_div=0, push 0xFF -> 0,1,1,1,1,1,1,1: 8 cycles total; 2 stop cycles high.
REQ-039 FIFO_DEPTH=4, hold in_valid for 6 bytes 0x01..0x06 during a long frame -> in_ready falls once level=4; all accepted bytes go out in order with no loss or duplication.
REQ-040 Change cfg_div 3->7 mid-frame -> current frame keeps 4-cycle bits and the next frame uses 8-cycle bits.
REQ-041 Assert rst during DATA with 3 bytes queued -> tx=1 and fifo_level=0 immediately; no tx_done; idle after release until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM state encoding, parity
// modes and data-length decode helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_t;

   localparam logic [1:0] PAR_NONE     = 2'd0;
   localparam logic [1:0] PAR_EVEN     = 2'd1;
   localparam logic [1:0] PAR_ODD      = 2'd2;
   localparam logic [1:0] PAR_NONE_ALT = 2'd3;

   localparam logic [1:0] DBITS_5 = 2'd0;
   localparam logic [1:0] DBITS_6 = 2'd1;
   localparam logic [1:0] DBITS_7 = 2'd2;
   localparam logic [1:0] DBITS_8 = 2'd3;

   // Index of the last data bit: 5 bits -> 4, ..., 8 bits -> 7.
   function automatic logic [2:0] last_bit_idx(input logic [1:0] dbits);
      return 3'd4 + {1'b0, dbits};
   endfunction

   function automatic logic [7:0] data_mask(input logic [1:0] dbits);
      logic [7:0] m;
      m = 8'hFF;
      case (dbits)
         DBITS_5: m = 8'h1F;
         DBITS_6: m = 8'h3F;
         DBITS_7: m = 8'h7F;
         DBITS_8: m = 8'hFF;
         default: m = 8'hFF;
      endcase
      return m;
   endfunction

   function automatic logic parity_on(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

   // Only the bits actually transmitted contribute to the parity.
   function automatic logic parity_bit(input logic [7:0] data, input logic [1:0] dbits,
                                       input logic [1:0] mode);
      logic p;
      p = ^(data & data_mask(dbits));
      return (mode == PAR_ODD) ? ~p : p;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy output. Storage is not reset; only the
// pointers and level are, which is enough to make the contents invisible.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_LVL);
   assign empty   = (count == '0);
   assign level   = count;
   assign rd_data = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter. Input handshake: a byte transfers on any rising
// edge where in_valid && in_ready; in_ready is low only while the FIFO is full.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int DIV_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [7:0]                    in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [DIV_W-1:0]              cfg_div,
   input  logic [1:0]                    cfg_dbits,
   input  logic [1:0]                    cfg_parity,
   input  logic                          cfg_stop2,
   output logic                          tx,
   output logic                          tx_busy,
   output logic                          tx_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   tx_state_t        state;
   logic [DIV_W-1:0] baud_cnt;
   logic [DIV_W-1:0] div_q;
   logic [7:0]       shreg;
   logic [2:0]       bit_idx;
   logic [1:0]       dbits_q;
   logic             par_en_q;
   logic             par_q;
   logic             stop2_q;
   logic             stop_idx;
   logic             bit_end;

   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic [7:0]       fifo_rd;

   assign in_ready = !fifo_full;
   assign fifo_pop = (state == ST_IDLE) && !fifo_empty;
   assign bit_end  = (baud_cnt == div_q);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (in_valid),
      .wr_data (in_data),
      .pop     (fifo_pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // tx and tx_done are registered from the state, so the line trails the
   // FSM by one cycle; this yields the idle-high gap between frames.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         div_q    <= '0;
         shreg    <= '0;
         bit_idx  <= '0;
         dbits_q  <= '0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         stop2_q  <= 1'b0;
         stop_idx <= 1'b0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            ST_START:  tx <= 1'b0;
            ST_DATA:   tx <= shreg[0];
            ST_PARITY: tx <= par_q;
            default:   tx <= 1'b1;
         endcase

         if (state == ST_IDLE) begin
            if (!fifo_empty) begin
               shreg    <= fifo_rd;
               div_q    <= cfg_div;
               dbits_q  <= cfg_dbits;
               par_en_q <= parity_on(cfg_parity);
               par_q    <= parity_bit(fifo_rd, cfg_dbits, cfg_parity);
               stop2_q  <= cfg_stop2;
               baud_cnt <= '0;
               bit_idx  <= '0;
               stop_idx <= 1'b0;
               tx_busy  <= 1'b1;
               state    <= ST_START;
            end
         end else if (!bit_end) begin
            baud_cnt <= baud_cnt + DIV_W'(1);
         end else begin
            baud_cnt <= '0;
            case (state)
               ST_START: state <= ST_DATA;
               ST_DATA: begin
                  shreg <= shreg >> 1;
                  if (bit_idx == last_bit_idx(dbits_q)) begin
                     state <= par_en_q ? ST_PARITY : ST_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
               ST_PARITY: state <= ST_STOP;
               ST_STOP: begin
                  if (stop2_q && !stop_idx) begin
                     stop_idx <= 1'b1;
                  end else begin
                     state   <= ST_IDLE;
                     tx_busy <= 1'b0;
                     tx_done <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus randomized frames, with the
// expected serial waveform built from the frame format rules.
module tb_uart_tx_fifo;

   localparam int DEPTH = 4;
   localparam int DIV_W = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [7:0]       in_data = 8'h00;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [DIV_W-1:0] cfg_div = '0;
   logic [1:0]       cfg_dbits = 2'd3;
   logic [1:0]       cfg_parity = 2'd0;
   logic             cfg_stop2 = 1'b0;
   logic             tx;
   logic             tx_busy;
   logic             tx_done;
   logic [LW-1:0]    fifo_level;

   logic [7:0] exp_q[$];
   logic [7:0] drv_q[$];
   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;

   uart_tx_fifo #(
      .FIFO_DEPTH (DEPTH),
      .DIV_W      (DIV_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .cfg_div    (cfg_div),
      .cfg_dbits  (cfg_dbits),
      .cfg_parity (cfg_parity),
      .cfg_stop2  (cfg_stop2),
      .tx         (tx),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog expired: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Feed drv_q into the DUT; each accepted byte enters the scoreboard.
   task automatic drive_all(input int max_gap);
      int w;
      while (drv_q.size() > 0) begin
         in_valid = 1'b1;
         in_data  = drv_q[0];
         w = 0;
         while (in_ready !== 1'b1 && w < 3000) begin
            @(negedge clk);
            w++;
         end
         if (in_ready !== 1'b1) begin
            chk("drive_timeout", 256'(in_ready), 256'(1));
            in_valid = 1'b0;
            drv_q.delete();
            return;
         end
         exp_q.push_back(drv_q.pop_front());
         @(negedge clk);
         in_valid = 1'b0;
         if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   // Wait for a start bit, then compare the whole frame cycle by cycle
   // against the waveform derived from the next scoreboard byte.
   task automatic check_frame(input string tag, input int div, input int dbits,
                              input int par, input bit stop2, input int exp_wait);
      int waited;
      int ones;
      int total;
      int idx;
      logic [7:0] b;
      bit bits[$];
      logic [255:0] ot, et, od, ed;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (tx !== 1'b0 && waited < 3000);
      if (tx !== 1'b0) begin
         chk({tag, "_start"}, 256'(tx), 256'(0));
         return;
      end
      if (exp_wait > 0) chk({tag, "_gap"}, 256'(waited), 256'(exp_wait));
      if (exp_q.size() == 0) begin
         chk({tag, "_scoreboard"}, 256'(exp_q.size()), 256'(1));
         return;
      end
      b = exp_q.pop_front();
      ones = 0;
      bits.push_back(1'b0);
      for (int k = 0; k < 5 + dbits; k++) begin
         bits.push_back(b[k]);
         ones += int'(b[k]);
      end
      if (par == 1) bits.push_back((ones % 2) == 1);
      if (par == 2) bits.push_back((ones % 2) == 0);
      bits.push_back(1'b1);
      if (stop2) bits.push_back(1'b1);
      total = bits.size() * (div + 1);
      ot = '0; et = '0; od = '0; ed = '0;
      for (int i = 0; i < total; i++) begin
         if (i > 0) @(negedge clk);
         idx = i / (div + 1);
         ot[i] = tx;
         od[i] = tx_done;
         et[i] = bits[idx];
         ed[i] = (i == total - 1);
      end
      chk({tag, "_tx"}, ot, et);
      chk({tag, "_done"}, od, ed);
   endtask

   initial begin
      int lows;
      int dones;
      int rdiv, rdb, rpar;
      bit rst2;

      repeat (3) @(negedge clk);
      chk("rst_tx", 256'(tx), 256'(1));
      chk("rst_level", 256'(fifo_level), 256'(0));
      chk("rst_ready", 256'(in_ready), 256'(1));
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", 256'(tx_busy), 256'(0));
      chk("idle_done", 256'(tx_done), 256'(0));
      chk("idle_tx", 256'(tx), 256'(1));

      // 8N1, 4-cycle bits, first byte into an idle block.
      cfg_div = 3; cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
      drv_q = '{8'hA5};
      drive_all(0);
      check_frame("8n1_a5", 3, 3, 0, 1'b0, 2);

      // 7 data bits, even then odd parity; the top bit of 0xD5 must be ignored.
      cfg_div = 1; cfg_dbits = 2'd2; cfg_parity = 2'd1;
      drv_q = '{8'h55};
      drive_all(0);
      check_frame("7e_55", 1, 2, 1, 1'b0, 2);
      cfg_parity = 2'd2;
      drv_q = '{8'hD5};
      drive_all(0);
      check_frame("7o_d5", 1, 2, 2, 1'b0, 2);

      // 5 data bits, two stop bits, one-cycle bits.
      cfg_div = 0; cfg_dbits = 2'd0; cfg_parity = 2'd3; cfg_stop2 = 1'b1;
      drv_q = '{8'hFF};
      drive_all(0);
      check_frame("5n2_ff", 0, 0, 0, 1'b1, 2);

      // Fill the FIFO during a long frame, then drain everything in order.
      cfg_div = 7; cfg_dbits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
      drv_q = '{8'h00};
      drive_all(0);
      fork
         begin
            repeat (5) @(negedge clk);
            for (int i = 1; i <= 4; i++) begin
               in_valid = 1'b1;
               in_data  = 8'(i);
               chk("fill_ready", 256'(in_ready), 256'(1));
               exp_q.push_back(8'(i));
               @(negedge clk);
            end
            chk("full_level", 256'(fifo_level), 256'(4));
            chk("full_ready", 256'(in_ready), 256'(0));
            drv_q = '{8'h05, 8'h06};
            drive_all(0);
         end
         begin
            check_frame("fill_f0", 7, 3, 0, 1'b0, 2);
            for (int i = 1; i <= 6; i++) check_frame($sformatf("fill_f%0d", i), 7, 3, 0, 1'b0, 2);
         end
      join
      chk("drain_level", 256'(fifo_level), 256'(0));

      // Divisor change mid-frame applies only to the next frame.
      cfg_div = 3;
      drv_q = '{8'h3C, 8'hC3};
      drive_all(0);
      fork
         begin
            check_frame("div3_frame", 3, 3, 0, 1'b0, 0);
            check_frame("div7_frame", 7, 3, 0, 1'b0, 2);
         end
         begin
            repeat (12) @(negedge clk);
            cfg_div = 7;
         end
      join

      // Reset during DATA with three bytes queued.
      cfg_div = 3;
      drv_q = '{8'h11, 8'h22, 8'h33, 8'h44};
      drive_all(0);
      repeat (8) @(negedge clk);
      chk("pre_rst_level", 256'(fifo_level), 256'(3));
      chk("pre_rst_busy", 256'(tx_busy), 256'(1));
      rst = 1'b1;
      #1;
      chk("mid_rst_tx", 256'(tx), 256'(1));
      chk("mid_rst_level", 256'(fifo_level), 256'(0));
      chk("mid_rst_ready", 256'(in_ready), 256'(1));
      chk("mid_rst_busy", 256'(tx_busy), 256'(0));
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      lows = 0; dones = 0;
      repeat (60) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
         if (tx_done !== 1'b0) dones++;
      end
      chk("post_rst_tx_low", 256'(lows), 256'(0));
      chk("post_rst_done", 256'(dones), 256'(0));
      chk("post_rst_level", 256'(fifo_level), 256'(0));
      drv_q = '{8'h5A};
      drive_all(0);
      check_frame("post_rst_5a", 3, 3, 0, 1'b0, 2);

      // Randomized configurations and bytes with random inter-push gaps.
      for (int c = 0; c < 4; c++) begin
         rdiv = $urandom_range(0, 2);
         rdb  = $urandom_range(0, 3);
         rpar = $urandom_range(0, 3);
         rst2 = 1'($urandom_range(0, 1));
         cfg_div = DIV_W'(rdiv); cfg_dbits = 2'(rdb); cfg_parity = 2'(rpar); cfg_stop2 = rst2;
         for (int i = 0; i < 5; i++) drv_q.push_back(8'($urandom_range(0, 255)));
         fork
            drive_all(25);
            for (int i = 0; i < 5; i++)
               check_frame($sformatf("rand%0d_%0d", c, i), rdiv, rdb,
                           (rpar == 3) ? 0 : rpar, rst2, 0);
         join
      end
      chk("end_level", 256'(fifo_level), 256'(0));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
